// File: rtl/dae_decoder_seq.sv
// dae_decoder_seq
//   Decoder half of the denoising autoencoder datapath. Expands two compressed
//   features into one reconstructed sample: a 2->4 dense ReLU layer followed by
//   a 4->1 linear layer. All 12 multiplies share a single MAC, one per cycle.
//
// Ports
//   clk, rst          rising-edge clock, synchronous active-high reset
//   in_valid/in_ready feature-pair handshake (feature0, feature1, signed)
//   w1_flat           layer-1 weights, slice k = 2*j + i (neuron j, input i)
//   b1_flat           layer-1 biases, slice j
//   w2_flat           layer-2 weights, slice j multiplies hidden[j]
//   b2                layer-2 bias
//   out_valid/out_ready/out_sample  reconstructed-sample handshake
//
// Weights are fixed point with FRAC_BITS fractional bits; features, biases,
// hidden values and the output share the integer scale of the features.
module dae_decoder_seq #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned FRAC_BITS = 6,
    parameter int unsigned ACC_W     = 20
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     feature0,
    input  logic [DATA_W-1:0]     feature1,
    input  logic [8*DATA_W-1:0]   w1_flat,
    input  logic [4*DATA_W-1:0]   b1_flat,
    input  logic [4*DATA_W-1:0]   w2_flat,
    input  logic [DATA_W-1:0]     b2,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_sample
);

    typedef logic signed [DATA_W-1:0]   data_t;
    typedef logic signed [ACC_W-1:0]    acc_t;
    typedef logic signed [2*DATA_W-1:0] prod_t;

    typedef enum logic [1:0] {StIdle, StL1, StL2, StOut} state_t;

    localparam acc_t AccMax = acc_t'((2 ** (DATA_W - 1)) - 1);
    localparam acc_t AccMin = acc_t'(-(2 ** (DATA_W - 1)));

    // Clamp an already-shifted accumulator value into the data range.
    function automatic data_t sat(input acc_t v);
        acc_t c;
        if (v > AccMax) begin
            c = AccMax;
        end else if (v < AccMin) begin
            c = AccMin;
        end else begin
            c = v;
        end
        return c[DATA_W-1:0];
    endfunction

    state_t state_q, state_d;

    logic [2:0] cnt_q;
    acc_t       acc_q;
    data_t      hidden_q [4];
    data_t      feat_q   [2];
    data_t      w1_q     [8];
    data_t      b1_q     [4];
    data_t      w2_q     [4];
    data_t      b2_q;
    data_t      out_sample_q;

    data_t mac_a, mac_b, bias;
    prod_t prod;
    acc_t  acc_sum, biased, shifted;
    data_t sat_val, relu_val;

    // ------------------------------------------------------------------
    // Shared MAC and neuron finishing logic
    // ------------------------------------------------------------------
    always_comb begin
        mac_a = '0;
        mac_b = '0;
        bias  = '0;
        unique case (state_q)
            StL1: begin
                // cnt = {j, i}: input i of neuron j
                mac_a = feat_q[cnt_q[0]];
                mac_b = w1_q[cnt_q];
                bias  = b1_q[cnt_q[2:1]];
            end
            StL2: begin
                mac_a = hidden_q[cnt_q[1:0]];
                mac_b = w2_q[cnt_q[1:0]];
                bias  = b2_q;
            end
            default: ;
        endcase
        prod     = mac_a * mac_b;
        acc_sum  = acc_q + acc_t'(prod);
        // Bias is on the feature scale; align it with the weight-scaled products.
        biased   = acc_sum + (acc_t'(bias) <<< FRAC_BITS);
        shifted  = biased >>> FRAC_BITS;
        sat_val  = sat(shifted);
        relu_val = sat_val[DATA_W-1] ? '0 : sat_val;
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (in_valid)       state_d = StL1;
            StL1:   if (cnt_q == 3'd7)  state_d = StL2;
            StL2:   if (cnt_q == 3'd3)  state_d = StOut;
            StOut:  if (out_ready)      state_d = StIdle;
            default:                    state_d = StIdle;
        endcase
    end

    assign in_ready   = (state_q == StIdle);
    assign out_valid  = (state_q == StOut);
    assign out_sample = out_sample_q;

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            acc_q        <= '0;
            out_sample_q <= '0;
            b2_q         <= '0;
            for (int k = 0; k < 8; k++) w1_q[k] <= '0;
            for (int k = 0; k < 4; k++) begin
                hidden_q[k] <= '0;
                b1_q[k]     <= '0;
                w2_q[k]     <= '0;
            end
            feat_q[0] <= '0;
            feat_q[1] <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        // Snapshot everything so the ports may change mid-sample.
                        feat_q[0] <= feature0;
                        feat_q[1] <= feature1;
                        for (int k = 0; k < 8; k++) w1_q[k] <= w1_flat[k*DATA_W +: DATA_W];
                        for (int k = 0; k < 4; k++) begin
                            b1_q[k] <= b1_flat[k*DATA_W +: DATA_W];
                            w2_q[k] <= w2_flat[k*DATA_W +: DATA_W];
                        end
                        b2_q  <= b2;
                        cnt_q <= '0;
                        acc_q <= '0;
                    end
                end
                StL1: begin
                    cnt_q <= cnt_q + 3'd1;  // wraps to 0 entering L2
                    if (cnt_q[0]) begin
                        hidden_q[cnt_q[2:1]] <= relu_val;
                        acc_q                <= '0;
                    end else begin
                        acc_q <= acc_sum;
                    end
                end
                StL2: begin
                    if (cnt_q == 3'd3) begin
                        out_sample_q <= sat_val;
                        acc_q        <= '0;
                        cnt_q        <= '0;
                    end else begin
                        acc_q <= acc_sum;
                        cnt_q <= cnt_q + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dae_decoder_seq.sv
module tb_dae_decoder_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  feature0, feature1;
    logic [63:0] w1_flat;
    logic [31:0] b1_flat;
    logic [31:0] w2_flat;
    logic [7:0]  b2;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_sample;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int out_cyc = 0;

    dae_decoder_seq dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .feature0   (feature0),
        .feature1   (feature1),
        .w1_flat    (w1_flat),
        .b1_flat    (b1_flat),
        .w2_flat    (w2_flat),
        .b2         (b2),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sample (out_sample)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check_eq(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int clamp8(input int v);
        if (v > 127) return 127;
        if (v < -128) return -128;
        return v;
    endfunction

    // Reference: the decoder equations evaluated with integer arithmetic.
    function automatic int model(input logic [7:0] f0, input logic [7:0] f1);
        int f [2];
        int h [4];
        int s, wa, wb, bb;
        f[0] = $signed(f0);
        f[1] = $signed(f1);
        for (int j = 0; j < 4; j++) begin
            wa = $signed(w1_flat[16*j +: 8]);
            wb = $signed(w1_flat[16*j+8 +: 8]);
            bb = $signed(b1_flat[8*j +: 8]);
            s  = f[0] * wa + f[1] * wb + bb * 64;
            h[j] = clamp8(s >>> 6);
            if (h[j] < 0) h[j] = 0;
        end
        s = $signed(b2) * 64;
        for (int j = 0; j < 4; j++) begin
            wa = $signed(w2_flat[8*j +: 8]);
            s  = s + h[j] * wa;
        end
        return clamp8(s >>> 6);
    endfunction

    task automatic set_unity();
        w1_flat = {8{8'd64}};
        b1_flat = '0;
        w2_flat = {4{8'd64}};
        b2      = 8'd0;
    endtask

    // Send one pair (call at a negedge) and follow it to completion.
    task automatic send(input logic [7:0] f0, input logic [7:0] f1, input int exp,
                        input int bp, input bit scramble, input bit hold, input string tag);
        int c0, hi, unst, waited;
        waited = 0;
        while (!in_ready && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        check_eq({tag, "_idle"}, int'(in_ready), 1);
        feature0  = f0;
        feature1  = f1;
        in_valid  = 1'b1;
        out_ready = (bp == 0);
        c0 = cyc;
        @(posedge clk);
        #1;
        if (!hold) in_valid = 1'b0;
        if (scramble) begin
            @(posedge clk);
            #1;
            w1_flat = {$urandom(), $urandom()};
            b1_flat = $urandom();
            w2_flat = $urandom();
            b2      = 8'($urandom());
        end
        hi = 0;
        do begin
            @(negedge clk);
            if (in_ready) hi++;
        end while (!out_valid && (cyc - c0) < 40);
        out_cyc = cyc;
        check_eq({tag, "_lat"}, cyc - c0, 13);
        check_eq({tag, "_busy"}, hi, 0);
        check_eq({tag, "_out"}, int'($signed(out_sample)), exp);
        if (bp > 0) begin
            unst = 0;
            for (int k = 1; k < bp; k++) begin
                @(negedge clk);
                if (!out_valid || int'($signed(out_sample)) != exp || in_ready) unst++;
            end
            check_eq({tag, "_hold"}, unst, 0);
            out_ready = 1'b1;
        end
        @(negedge clk);
        check_eq({tag, "_done"}, int'({in_ready, out_valid}), 2);
    endtask

    task automatic reset_mid_l2();
        int seen;
        set_unity();
        feature0  = 8'd10;
        feature1  = 8'd20;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(negedge clk);  // cycle 10: inside L2
        rst = 1'b1;
        @(negedge clk);
        check_eq("rst_mid", int'({in_ready, out_valid, out_sample}), 512);
        rst  = 1'b0;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check_eq("rst_no_out", seen, 0);
        send(8'd10, 8'd20, 120, 0, 1'b0, 1'b0, "post_rst");
    endtask

    initial begin
        int exp, oc;
        logic [7:0] f0, f1;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        feature0 = '0; feature1 = '0;
        set_unity();
        repeat (2) @(negedge clk);
        check_eq("reset", int'({in_ready, out_valid, out_sample}), 512);
        rst = 1'b0;
        @(negedge clk);

        send(8'd10, 8'd20, 120, 0, 1'b0, 1'b0, "pass");
        send(8'd127, 8'd127, 127, 0, 1'b0, 1'b0, "sat_hi");
        w2_flat = {4{8'hC0}};
        send(8'd127, 8'd127, -128, 0, 1'b0, 1'b0, "sat_lo");
        w1_flat = {8{8'hC0}}; w2_flat = {4{8'd64}}; b2 = 8'hFB;
        send(8'd10, 8'd10, -5, 0, 1'b0, 1'b0, "relu");
        w1_flat = 64'h1; b1_flat = '0; w2_flat = '0; b2 = '0;
        send(8'd10, 8'd0, 0, 0, 1'b0, 1'b0, "trunc");

        set_unity();
        send(8'd10, 8'd20, 120, 5, 1'b0, 1'b0, "bp");
        send(8'd10, 8'd20, 120, 0, 1'b1, 1'b0, "wchg");

        reset_mid_l2();

        set_unity();
        send(8'd10, 8'd20, 120, 0, 1'b0, 1'b1, "b2b0");
        oc = out_cyc;
        send(8'd1, 8'd2, 12, 0, 1'b0, 1'b1, "b2b1");
        check_eq("b2b_gap1", out_cyc - oc, 14);
        oc = out_cyc;
        send(8'd5, 8'd5, 40, 0, 1'b0, 1'b0, "b2b2");
        check_eq("b2b_gap2", out_cyc - oc, 14);

        for (int n = 0; n < 40; n++) begin
            w1_flat = {$urandom(), $urandom()};
            b1_flat = $urandom();
            w2_flat = $urandom();
            b2      = 8'($urandom());
            f0      = 8'($urandom());
            f1      = 8'($urandom());
            exp     = model(f0, f1);
            send(f0, f1, exp, int'($urandom_range(0, 3)), 1'($urandom()), 1'b0, "rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
